bpsk_demodulator: RTL and testbench
===================================

Name: bpsk_demodulator

Overview:
- Downstream of the modulator: consumes the noisy 8-bit offset-binary waveform (modulator sine plus pseudo-random noise) at one sample per clk_fast cycle.
- Recovers the transmitted bit stream by correlating each SAMPLES_PER_BIT-sample symbol against a square-wave sign template.
- Emits one decided bit per symbol with a one-cycle strobe and a low-confidence flag.
- Feeds the bit-error checker and the loopback display logic.

Parameters:
- SAMPLES_PER_BIT, 16, samples per symbol; must equal the modulator's fast/slow clock ratio.
- DATA_W, 8, waveform sample width, unsigned offset-binary.
- MIDSCALE, 128, DC level subtracted from every sample.
- ACC_W, 13, signed accumulator width.
- START_OFFSET, 2, valid samples discarded after en rises before symbol 0 begins (modulator pipeline delay).
- CONF_THRESH, 64, |acc| strictly below this sets low_conf.

Ports:
- clk_fast  in  1  sample clock, one sample per cycle when in_valid=1.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  link enable, the same signal as the modulator valid.
- in_valid  in  1  qualifies wav_in this cycle.
- wav_in  in  DATA_W  received sample, unsigned.
- bit_out  out  1  decided bit, held until the next decision.
- bit_valid  out  1  one-cycle strobe, new bit_out.
- low_conf  out  1  confidence flag for the current bit_out, held with it.
- bit_count  out  16  number of decisions since en rose; wraps 65535 to 0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; acc=0, sample_idx=0, skip_cnt=0; bit_out=0, bit_valid=0, low_conf=0, bit_count=0.
- All logic is on posedge clk_fast. A sample is accepted only when in_valid=1 and the state is SKIP or ACCUM.
- FSM states:
  - IDLE: en=1 moves to SKIP (START_OFFSET>0) or ACCUM (START_OFFSET=0). skip_cnt=0, acc=0, sample_idx=0, bit_count=0 on entry.
  - SKIP: each accepted sample increments skip_cnt. The START_OFFSET-th accepted sample moves to ACCUM; that sample is not correlated.
  - ACCUM: each accepted sample computes d = wav_in - MIDSCALE (signed, DATA_W+1 bits).
    - sample_idx < SAMPLES_PER_BIT/2: acc += d.
    - Otherwise: acc -= d.
    - sample_idx increments. On sample_idx = SAMPLES_PER_BIT-1, a decision is made instead (below).
- Decision (final sample of a symbol):
  - Compute acc_final = acc ± d.
  - Next cycle: bit_out = (acc_final > 0), bit_valid=1, low_conf = (|acc_final| < CONF_THRESH), bit_count += 1.
  - In the same clock edge: acc=0, sample_idx=0. Latency from the final sample's accept edge to bit_valid high is 1 cycle.
  - acc_final = 0 decides 0 and sets low_conf.
- Gaps: in_valid=0 in SKIP/ACCUM freezes acc, sample_idx and skip_cnt. No timeout.
- bit_valid is high for exactly one cycle per decision and low otherwise.
- en=0 in any state returns to IDLE on the next edge and discards the partial symbol (no decision). bit_out, low_conf and bit_count hold their last values until en rises again.
  - If the final sample and en=0 coincide, the decision is still issued; the state goes to IDLE.
- Arithmetic: |d| ≤ 128 and 16 samples give |acc| ≤ 2048, so ACC_W=13 never overflows. No saturation logic is required.
- Symbol convention: bit 1 = sine starting at phase 0 (positive half-cycle first); bit 0 = phase π.

Decomposition:
- Shared package modem_pkg holds:
  - SAMPLES_PER_BIT, DATA_W, MIDSCALE, shared with the modulator and noise generator.
  - The state enum {IDLE, SKIP, ACCUM}.
- One sub-module: bpsk_correlator. It holds the signed accumulate/subtract datapath with clear and freeze inputs, and outputs acc_final.
- The FSM, counters and decision register stay in the top module.

Test Plan:
- START_OFFSET=2, en rises, 2 junk samples, then 8×200 followed by 8×56 → acc_final=+1152; one cycle later bit_valid=1, bit_out=1, low_conf=0, bit_count=1.
- Next symbol 8×56 followed by 8×200 → acc_final=-1152; bit_out=0, low_conf=0, bit_count=2; bit_valid high for exactly 1 cycle.
- 16×128 → acc_final=0; bit_out=0, low_conf=1. Then 8×132 followed by 8×124 → acc_final=+64; bit_out=1, low_conf=0 (64 is not < 64).
- 8×200/8×56 symbol with in_valid dropped for 5 cycles after sample 6 → same decision (+1152), issued 5 cycles later than without the gap.
- en deasserted after 10 samples of a symbol, re-asserted → no bit_valid for the aborted symbol; bit_count restarts at 1 on the next full symbol after START_OFFSET skips.
- rst asserted mid-symbol → all outputs 0 immediately (asynchronous); after release with en=1, the full skip and accumulate sequence decodes correctly.

Source files
------------

// File: rtl/modem_pkg.sv
// Constants and types shared by the modulator, noise generator and demodulator.
// Sample format and symbol length must agree across the whole link.
package modem_pkg;

  localparam int SAMPLES_PER_BIT = 16;
  localparam int DATA_W          = 8;
  localparam int MIDSCALE        = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    ACCUM = 2'd2
  } demod_state_e;

endpackage

// File: rtl/bpsk_correlator.sv
// Square-wave correlator: adds or subtracts the DC-removed sample into a signed
// accumulator. acc_final is the combinational running sum including this sample.
module bpsk_correlator
  import modem_pkg::*;
#(
  parameter int ACC_W = 13
) (
  input  logic                    clk_fast,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    freeze,
  input  logic                    negate,
  input  logic [DATA_W-1:0]       sample,
  output logic signed [ACC_W-1:0] acc_final
);

  logic signed [DATA_W:0]    d;
  logic signed [ACC_W-1:0]   d_ext;
  logic signed [ACC_W-1:0]   acc_reg;

  // Offset-binary to two's complement; one extra bit holds -128..+127.
  assign d     = $signed({1'b0, sample}) - $signed((DATA_W+1)'(MIDSCALE));
  assign d_ext = {{(ACC_W-DATA_W-1){d[DATA_W]}}, d};

  assign acc_final = negate ? (acc_reg - d_ext) : (acc_reg + d_ext);

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (!freeze) begin
      acc_reg <= acc_final;
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK demodulator: skips the modulator pipeline delay, correlates each symbol
// against a +/- square template and issues one bit decision per symbol.
module bpsk_demodulator
  import modem_pkg::*;
#(
  parameter int ACC_W        = 13,
  parameter int START_OFFSET = 2,
  parameter int CONF_THRESH  = 64
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] wav_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              low_conf,
  output logic [15:0]       bit_count
);

  localparam int IDX_W  = $clog2(SAMPLES_PER_BIT);
  localparam int HALF   = SAMPLES_PER_BIT / 2;
  localparam int SKIP_W = (START_OFFSET > 0) ? $clog2(START_OFFSET + 1) : 1;

  demod_state_e state_reg, state_next;
  logic [IDX_W-1:0]  sample_idx_reg, sample_idx_next;
  logic [SKIP_W-1:0] skip_cnt_reg, skip_cnt_next;

  logic        bit_out_reg, bit_valid_reg, low_conf_reg;
  logic [15:0] bit_count_reg;

  logic accept, last_sample;
  logic corr_clear, corr_freeze, corr_negate;
  logic signed [ACC_W-1:0] acc_final;
  logic [ACC_W-1:0]        acc_mag;

  assign accept      = in_valid && ((state_reg == SKIP) || (state_reg == ACCUM));
  assign last_sample = accept && (state_reg == ACCUM)
                       && (sample_idx_reg == IDX_W'(SAMPLES_PER_BIT - 1));

  always_comb begin
    state_next      = state_reg;
    sample_idx_next = sample_idx_reg;
    skip_cnt_next   = skip_cnt_reg;
    case (state_reg)
      IDLE: begin
        sample_idx_next = '0;
        skip_cnt_next   = '0;
        if (en) state_next = (START_OFFSET > 0) ? SKIP : ACCUM;
      end
      SKIP: begin
        if (in_valid) begin
          skip_cnt_next = skip_cnt_reg + 1'b1;
          if (skip_cnt_reg == SKIP_W'(START_OFFSET - 1)) state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          sample_idx_next = last_sample ? '0 : sample_idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Dropping the link wins over every transition; a coinciding decision still fires.
    if (!en) state_next = IDLE;
  end

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      sample_idx_reg <= '0;
      skip_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      sample_idx_reg <= sample_idx_next;
      skip_cnt_reg   <= skip_cnt_next;
    end
  end

  assign corr_clear  = (state_reg == IDLE) || last_sample;
  assign corr_freeze = !(accept && (state_reg == ACCUM));
  assign corr_negate = (sample_idx_reg >= IDX_W'(HALF));

  bpsk_correlator #(
    .ACC_W (ACC_W)
  ) u_correlator (
    .clk_fast  (clk_fast),
    .rst       (rst),
    .clear     (corr_clear),
    .freeze    (corr_freeze),
    .negate    (corr_negate),
    .sample    (wav_in),
    .acc_final (acc_final)
  );

  assign acc_mag = acc_final[ACC_W-1] ? ACC_W'(-acc_final) : ACC_W'(acc_final);

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
      low_conf_reg  <= 1'b0;
      bit_count_reg <= '0;
    end else begin
      bit_valid_reg <= last_sample;
      if (last_sample) begin
        bit_out_reg   <= (acc_final > 0);
        low_conf_reg  <= (acc_mag < ACC_W'(CONF_THRESH));
        bit_count_reg <= bit_count_reg + 16'd1;
      end else if ((state_reg == IDLE) && en) begin
        bit_count_reg <= '0;
      end
    end
  end

  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign low_conf  = low_conf_reg;
  assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Bench for bpsk_demodulator: table of fixed symbols, random noisy symbols
// checked against a sum-of-halves model, and hand sequences for gaps, abort and reset.
module tb_bpsk_demodulator;

  typedef logic [7:0] sym_t [16];

  typedef struct {
    logic [7:0] h1;
    logic [7:0] h2;
    logic       eb;
    logic       el;
  } vec_t;

  logic        clk_fast = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [7:0]  wav_in;
  logic        bit_out;
  logic        bit_valid;
  logic        low_conf;
  logic [15:0] bit_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  vec_t tbl [9];

  bpsk_demodulator dut (
    .clk_fast  (clk_fast),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .wav_in    (wav_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .low_conf  (low_conf),
    .bit_count (bit_count)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    wav_in   = d;
    @(posedge clk_fast);
    #1;
  endtask

  function automatic sym_t halves(input logic [7:0] a, input logic [7:0] b);
    sym_t r;
    for (int i = 0; i < 16; i++) r[i] = (i < 8) ? a : b;
    return r;
  endfunction

  // Reference: correlation = sum(first half) - sum(second half) of (sample - 128).
  function automatic void model_decide(input sym_t s, output logic b, output logic l);
    int sum = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) sum += int'(s[i]) - 128;
      else       sum -= int'(s[i]) - 128;
    end
    b = (sum > 0);
    l = ((sum < 0) ? -sum : sum) < 64;
  endfunction

  // en rises: one cycle in IDLE (sample ignored), then two junk samples skipped.
  task automatic start_link();
    en = 1'b1;
    drive(1'b0, 8'h00);
    check("cnt_clear_on_en", int'(bit_count), 0);
    exp_count = 0;
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'h00);
  endtask

  task automatic send_symbol(input sym_t s, input int gap_at, input int gap_len,
                             input bit rand_gaps, input bit en_off_last,
                             input logic eb, input logic el, input string tag);
    int cycles = 0;
    int early  = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          drive(1'b0, 8'($urandom_range(0, 255)));
          cycles++;
          if (bit_valid) early++;
        end
      end
      if (rand_gaps && ($urandom_range(0, 3) == 0)) begin
        drive(1'b0, 8'($urandom_range(0, 255)));
        cycles++;
        if (bit_valid) early++;
      end
      if (i == 15 && en_off_last) en = 1'b0;
      drive(1'b1, s[i]);
      cycles++;
      if (i < 15 && bit_valid) early++;
    end
    exp_count = (exp_count + 1) & 16'hFFFF;
    check($sformatf("%s_early_strobe", tag), early, 0);
    check($sformatf("%s_bit_valid", tag), int'(bit_valid), 1);
    check($sformatf("%s_bit_out", tag), int'(bit_out), int'(eb));
    check($sformatf("%s_low_conf", tag), int'(low_conf), int'(el));
    check($sformatf("%s_bit_count", tag), int'(bit_count), exp_count);
    if (gap_at >= 0) check($sformatf("%s_latency", tag), cycles, 16 + gap_len);
    $display("symbol %s: bit_out=%0d low_conf=%0d bit_count=%0d cycles=%0d",
             tag, bit_out, low_conf, bit_count, cycles);
  endtask

  initial begin
    logic eb, el;
    sym_t s;
    int   strobes;

    tbl[0] = '{8'd200, 8'd56,  1'b1, 1'b0};  // +1152
    tbl[1] = '{8'd56,  8'd200, 1'b0, 1'b0};  // -1152
    tbl[2] = '{8'd128, 8'd128, 1'b0, 1'b1};  // 0
    tbl[3] = '{8'd132, 8'd124, 1'b1, 1'b0};  // +64, not below threshold
    tbl[4] = '{8'd124, 8'd132, 1'b0, 1'b0};  // -64
    tbl[5] = '{8'd131, 8'd125, 1'b1, 1'b1};  // +48
    tbl[6] = '{8'd129, 8'd128, 1'b1, 1'b1};  // +8
    tbl[7] = '{8'd255, 8'd0,   1'b1, 1'b0};  // +2040
    tbl[8] = '{8'd0,   8'd255, 1'b0, 1'b0};  // -2040

    rst = 1'b0; en = 1'b0; in_valid = 1'b0; wav_in = 8'h00;
    repeat (3) @(posedge clk_fast);
    #1;
    check("rst_bit_out",   int'(bit_out),   0);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_low_conf",  int'(low_conf),  0);
    check("rst_bit_count", int'(bit_count), 0);
    rst = 1'b1;
    drive(1'b1, 8'd200);

    start_link();
    for (int t = 0; t < 9; t++)
      send_symbol(halves(tbl[t].h1, tbl[t].h2), -1, 0, 1'b0, 1'b0,
                  tbl[t].eb, tbl[t].el, $sformatf("tbl%0d", t));

    // Five idle cycles inside a symbol delay the decision by exactly five cycles.
    send_symbol(halves(8'd200, 8'd56), 7, 5, 1'b0, 1'b0, 1'b1, 1'b0, "gap");

    for (int r = 0; r < 24; r++) begin
      int b   = int'($urandom_range(0, 1));
      int amp = int'($urandom_range(0, 70));
      for (int i = 0; i < 16; i++) begin
        int v = 128 + (((i < 8) == (b == 1)) ? amp : -amp) + int'($urandom_range(0, 60)) - 30;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        s[i] = 8'(v);
      end
      model_decide(s, eb, el);
      send_symbol(s, -1, 0, 1'b1, 1'b0, eb, el, $sformatf("rnd%0d", r));
    end

    // Abort after 10 samples: no decision, count holds, then restarts from 1.
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'd200);
      if (bit_valid && i > 0) strobes++;
    end
    en = 1'b0;
    drive(1'b1, 8'd200);
    if (bit_valid) strobes++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'd56);
      if (bit_valid) strobes++;
    end
    check("abort_no_strobe", strobes, 0);
    check("abort_cnt_hold", int'(bit_count), exp_count);
    start_link();
    send_symbol(halves(8'd200, 8'd56), -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, "restart");

    // en drops together with the final sample: the decision still fires.
    send_symbol(halves(8'd56, 8'd200), -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "en_last");
    drive(1'b1, 8'd200);
    check("en_last_strobe_off", int'(bit_valid), 0);
    check("en_last_hold_cnt", int'(bit_count), exp_count);

    // Asynchronous reset mid-symbol.
    start_link();
    send_symbol(halves(8'd200, 8'd56), -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_rst");
    for (int i = 0; i < 7; i++) drive(1'b1, 8'd200);
    rst = 1'b0;
    #2;
    check("arst_bit_out",   int'(bit_out),   0);
    check("arst_bit_valid", int'(bit_valid), 0);
    check("arst_low_conf",  int'(low_conf),  0);
    check("arst_bit_count", int'(bit_count), 0);
    @(posedge clk_fast);
    #1;
    rst = 1'b1;
    start_link();
    send_symbol(halves(8'd200, 8'd56), -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, "post_rst");
    send_symbol(halves(8'd128, 8'd128), -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst_zero");
    drive(1'b0, 8'd0);
    check("final_strobe_off", int'(bit_valid), 0);
    check("final_hold_low_conf", int'(low_conf), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
